// File: rtl/proj_fm_ring_if.sv
// Bus bundle for proj_fm_ring: symbol write stream, buffer-advance control and
// fragment read port.
interface proj_fm_ring_if #(
   parameter int DATA_BITS         = 2,
   parameter int FRAG_LEN          = 32,
   parameter int SIGNED_INDICE_LEN = 9,
   parameter int AVAIL_W           = 3
);
   // Write handshake: a symbol transfers on a rising edge where in_valid and
   // in_ready are both high; in_valid may rise without waiting for in_ready.
   logic                         in_valid;
   logic [DATA_BITS-1:0]         in_wdata;
   logic                         in_ready;
   logic                         chg_idx;
   logic                         chg_err;
   logic                         rd_en;
   logic [SIGNED_INDICE_LEN-1:0] frag_idx;
   logic                         out_valid;
   logic [FRAG_LEN-1:0]          out_rdata;
   logic                         out_oob;
   logic [AVAIL_W-1:0]           buf_avail;

   modport master (
      output in_valid, in_wdata, chg_idx, rd_en, frag_idx,
      input  in_ready, chg_err, out_valid, out_rdata, out_oob, buf_avail
   );

   modport slave (
      input  in_valid, in_wdata, chg_idx, rd_en, frag_idx,
      output in_ready, chg_err, out_valid, out_rdata, out_oob, buf_avail
   );
endinterface

// File: rtl/proj_fm_ring.sv
// N-buffer ring fragment memory: serial symbols fill ring buffers, chg_idx promotes
// the oldest committed buffer to active, and signed-index windows read active/history.
module proj_fm_ring #(
   parameter int BUFFER_COUNT      = 4,
   parameter int DATA_BITS         = 2,
   parameter int DEPTH             = 64,
   parameter int FRAG_LEN          = 32,
   parameter int SIGNED_INDICE_LEN = 9,
   parameter int HIST_EN           = 1
) (
   input logic             clk,
   input logic             rst_n,
   proj_fm_ring_if.slave   bus
);
   localparam int BUF_BITS = DEPTH * DATA_BITS;
   localparam int PTR_W    = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1;
   localparam int CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AVAIL_W  = $clog2(BUFFER_COUNT + 1);
   localparam int OCC_W    = AVAIL_W + 1;
   localparam int IW       = SIGNED_INDICE_LEN + 1;
   localparam int BB_W     = $clog2(BUF_BITS);
   localparam logic signed [IW-1:0] BB_S = IW'(BUF_BITS);

   logic [BUF_BITS-1:0] mem [BUFFER_COUNT];

   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   wr_cnt;
   logic [AVAIL_W-1:0] filled;
   logic [PTR_W-1:0]   act_ptr;
   logic               act_vld;
   logic [PTR_W-1:0]   hist_ptr;
   logic               hist_vld;
   logic               chg_err_q;
   logic               out_valid_q;
   logic [FRAG_LEN-1:0] out_rdata_q;
   logic               out_oob_q;

   logic [OCC_W-1:0]   occupancy;
   logic               in_ready_c;
   logic               wr_fire;
   logic               commit;
   logic               chg_ok;
   logic [PTR_W-1:0]   wr_ptr_next;
   logic [PTR_W-1:0]   oldest_ptr;
   logic [PTR_W:0]     oldest_sum;
   logic [BUF_BITS-1:0] act_buf;
   logic [BUF_BITS-1:0] hist_buf;
   logic               hist_ok;
   logic [FRAG_LEN:0]  rd_word;

   // Bit j comes from position idx+j, evaluated one bit wider than idx so the
   // addition never wraps; anything outside active/history is zero and flagged.
   function automatic logic [FRAG_LEN:0] read_window(
      input logic [BUF_BITS-1:0]          a_buf,
      input logic [BUF_BITS-1:0]          h_buf,
      input logic                         a_ok,
      input logic                         h_ok,
      input logic [SIGNED_INDICE_LEN-1:0] idx
   );
      logic [FRAG_LEN-1:0]   data;
      logic                  oob;
      logic signed [IW-1:0]  base;
      logic signed [IW-1:0]  p;
      data = '0;
      oob  = 1'b0;
      base = $signed({idx[SIGNED_INDICE_LEN-1], idx});
      p    = '0;
      if (!a_ok) begin
         oob = 1'b1;
      end else begin
         for (int j = 0; j < FRAG_LEN; j++) begin
            p = base + $signed(IW'(j));
            if (!p[IW-1] && (p < BB_S)) begin
               data[j] = a_buf[p[BB_W-1:0]];
            end else if (p[IW-1] && (p >= -BB_S) && h_ok) begin
               data[j] = h_buf[BB_W'(p + BB_S)];
            end else begin
               oob = 1'b1;
            end
         end
      end
      return {oob, data};
   endfunction

   always_comb begin
      occupancy  = OCC_W'(filled) + OCC_W'(act_vld) + OCC_W'(hist_vld);
      in_ready_c = (occupancy < OCC_W'(BUFFER_COUNT));
      wr_fire    = bus.in_valid && in_ready_c;
      commit     = wr_fire && (wr_cnt == CNT_W'(DEPTH - 1));
      chg_ok     = bus.chg_idx && (filled != '0);
      wr_ptr_next = (wr_ptr == PTR_W'(BUFFER_COUNT - 1)) ? '0 : wr_ptr + 1'b1;
   end

   // Buffers sit contiguously in ring order (history, active, committed...,
   // write), so the oldest committed buffer is wr_ptr - filled modulo the ring.
   always_comb begin
      oldest_sum = {1'b0, wr_ptr} + (PTR_W+1)'(BUFFER_COUNT) - (PTR_W+1)'(filled);
      if (oldest_sum >= (PTR_W+1)'(BUFFER_COUNT)) begin
         oldest_sum = oldest_sum - (PTR_W+1)'(BUFFER_COUNT);
      end
      oldest_ptr = oldest_sum[PTR_W-1:0];
   end

   always_comb begin
      act_buf  = mem[act_ptr];
      hist_buf = mem[hist_ptr];
      hist_ok  = (HIST_EN != 0) && hist_vld;
      rd_word  = read_window(act_buf, hist_buf, act_vld, hist_ok, bus.frag_idx);
   end

   // Storage carries no reset: stale contents are unreachable once the valid
   // flags and counters clear.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr][wr_cnt*DATA_BITS +: DATA_BITS] <= bus.in_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         wr_cnt      <= '0;
         filled      <= '0;
         act_ptr     <= '0;
         act_vld     <= 1'b0;
         hist_ptr    <= '0;
         hist_vld    <= 1'b0;
         chg_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_rdata_q <= '0;
         out_oob_q   <= 1'b0;
      end else begin
         chg_err_q <= bus.chg_idx && (filled == '0);

         if (wr_fire) begin
            if (commit) begin
               wr_cnt <= '0;
               wr_ptr <= wr_ptr_next;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end

         // A same-cycle commit is invisible to chg_idx; both together cancel out.
         if (commit && !chg_ok) begin
            filled <= filled + 1'b1;
         end else if (!commit && chg_ok) begin
            filled <= filled - 1'b1;
         end

         if (chg_ok) begin
            act_ptr <= oldest_ptr;
            act_vld <= 1'b1;
            if ((HIST_EN != 0) && act_vld) begin
               hist_ptr <= act_ptr;
               hist_vld <= 1'b1;
            end else begin
               hist_vld <= 1'b0;
            end
         end

         out_valid_q <= bus.rd_en;
         if (bus.rd_en) begin
            out_oob_q   <= rd_word[FRAG_LEN];
            out_rdata_q <= rd_word[FRAG_LEN-1:0];
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.chg_err   = chg_err_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_rdata = out_rdata_q;
   assign bus.out_oob   = out_oob_q;
   assign bus.buf_avail = filled;
endmodule

// File: tb/tb_proj_fm_ring.sv
// Bench for proj_fm_ring: directed scenarios plus random traffic against a
// queue-of-buffers reference model; read results go through a scoreboard.
module tb_proj_fm_ring;
   localparam int BC    = 4;
   localparam int DB    = 2;
   localparam int DEPTH = 64;
   localparam int BB    = DEPTH * DB;
   localparam int FL    = 32;
   localparam int SIL   = 9;
   localparam int HIST  = 1;
   localparam int AW    = $clog2(BC + 1);

   logic clk;
   logic rst_n;

   proj_fm_ring_if #(.DATA_BITS(DB), .FRAG_LEN(FL), .SIGNED_INDICE_LEN(SIL), .AVAIL_W(AW)) bus ();

   proj_fm_ring #(
      .BUFFER_COUNT(BC), .DATA_BITS(DB), .DEPTH(DEPTH), .FRAG_LEN(FL),
      .SIGNED_INDICE_LEN(SIL), .HIST_EN(HIST)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [BB-1:0] m_q[$];
   logic [BB-1:0] m_part;
   int            m_cnt;
   logic [BB-1:0] m_act;
   logic [BB-1:0] m_hist;
   bit            m_act_v;
   bit            m_hist_v;
   bit            m_chg_err;

   logic [FL:0]   exp_q[$];
   logic [FL:0]   mon_exp;
   int            n_checks;
   int            n_fail;

   function automatic int occ();
      return m_q.size() + int'(m_act_v) + int'(m_hist_v);
   endfunction

   function automatic logic [FL:0] model_read(input int idx);
      logic [FL-1:0] d;
      logic          o;
      int            p;
      d = '0;
      o = 1'b0;
      if (!m_act_v) return {1'b1, {FL{1'b0}}};
      for (int j = 0; j < FL; j++) begin
         p = idx + j;
         if (p >= 0 && p < BB) d[j] = m_act[p];
         else if (p < 0 && p >= -BB && HIST != 0 && m_hist_v) d[j] = m_hist[BB + p];
         else o = 1'b1;
      end
      return {o, d};
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_part    = '0;
      m_cnt     = 0;
      m_act     = '0;
      m_hist    = '0;
      m_act_v   = 0;
      m_hist_v  = 0;
      m_chg_err = 0;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge; drives one cycle and checks the
   // registered outputs just after the next rising edge.
   task automatic step(input logic v, input logic [DB-1:0] w, input logic c,
                       input logic r, input int idx,
                       input logic use_exp, input logic [FL:0] exp_rd);
      logic acc;
      bus.in_valid = v;
      bus.in_wdata = w;
      bus.chg_idx  = c;
      bus.rd_en    = r;
      bus.frag_idx = idx[SIL-1:0];
      acc = v && (occ() < BC);
      if (r) exp_q.push_back(use_exp ? exp_rd : model_read(idx));
      @(posedge clk);
      m_chg_err = c && (m_q.size() == 0);
      if (c && m_q.size() > 0) begin
         if (HIST != 0 && m_act_v) begin
            m_hist   = m_act;
            m_hist_v = 1;
         end else begin
            m_hist_v = 0;
         end
         m_act   = m_q.pop_front();
         m_act_v = 1;
      end
      if (acc) begin
         m_part[m_cnt*DB +: DB] = w;
         m_cnt++;
         if (m_cnt == DEPTH) begin
            m_q.push_back(m_part);
            m_part = '0;
            m_cnt  = 0;
         end
      end
      #1;
      chk("in_ready",  64'(bus.in_ready),  64'(occ() < BC));
      chk("buf_avail", 64'(bus.buf_avail), 64'(m_q.size()));
      chk("chg_err",   64'(bus.chg_err),   64'(m_chg_err));
      chk("out_valid", 64'(bus.out_valid), 64'(r));
   endtask

   task automatic idle();
      step(0, '0, 0, 0, 0, 0, '0);
   endtask

   task automatic wr(input logic [DB-1:0] w);
      step(1, w, 0, 0, 0, 0, '0);
   endtask

   task automatic chg();
      step(0, '0, 1, 0, 0, 0, '0);
   endtask

   task automatic rd(input int idx);
      step(0, '0, 0, 1, idx, 0, '0);
   endtask

   task automatic rd_const(input int idx, input logic [FL:0] e);
      step(0, '0, 0, 1, idx, 1, e);
   endtask

   task automatic apply_reset();
      bus.in_valid = 0;
      bus.in_wdata = '0;
      bus.chg_idx  = 0;
      bus.rd_en    = 0;
      bus.frag_idx = '0;
      rst_n = 0;
      #2;
      model_clear();
      exp_q.delete();
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst_buf_avail", 64'(bus.buf_avail), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_rdata", 64'(bus.out_rdata), 64'd0);
      chk("rst_out_oob",   64'(bus.out_oob),   64'd0);
      chk("rst_chg_err",   64'(bus.chg_err),   64'd0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL read_unexpected: got oob=%0b data=%h, required no result", bus.out_oob, bus.out_rdata);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({bus.out_oob, bus.out_rdata} !== mon_exp) begin
               n_fail++;
               $display("FAIL read_data: got oob=%0b data=%h, required oob=%0b data=%h (t=%0t)",
                        bus.out_oob, bus.out_rdata, mon_exp[FL], mon_exp[FL-1:0], $time);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_clear();
      rst_n = 0;
      repeat (2) @(posedge clk);
      apply_reset();

      // reset in the middle of filling a buffer
      for (int k = 0; k < 30; k++) wr(DB'($urandom_range(0, 3)));
      apply_reset();
      rd_const(0, {1'b1, 32'h0});

      // basic read and window edges
      for (int k = 0; k < DEPTH; k++) wr(DB'(k % 4));
      chg();
      rd_const(0,   {1'b0, 32'hE4E4E4E4});
      rd_const(96,  {1'b0, 32'hE4E4E4E4});
      rd_const(100, {1'b1, 32'h0E4E4E4E});
      rd(-5);
      rd(-200);

      // history read
      for (int k = 0; k < DEPTH; k++) wr(2'b11);
      for (int k = 0; k < DEPTH; k++) wr(2'b00);
      chg();
      chg();
      rd_const(-2, {1'b0, 32'h00000003});
      rd(-130);

      // backpressure
      apply_reset();
      for (int k = 0; k < BC * DEPTH; k++) wr(DB'($urandom_range(0, 3)));
      chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_full_avail", 64'(bus.buf_avail), 64'd4);
      wr(2'b01);
      chg();
      chg();
      chk("bp_two_chg_ready", 64'(bus.in_ready), 64'd0);
      chg();
      chk("bp_three_chg_ready", 64'(bus.in_ready), 64'd1);
      chk("bp_three_chg_avail", 64'(bus.buf_avail), 64'd1);

      // empty change
      chg();
      rd(7);
      chg();
      chk("empty_chg_err", 64'(bus.chg_err), 64'd1);
      idle();
      chk("empty_chg_err_drop", 64'(bus.chg_err), 64'd0);
      rd(7);
      for (int k = 0; k < DEPTH - 1; k++) wr(DB'($urandom_range(0, 3)));
      step(1, 2'b10, 1, 0, 0, 0, '0);
      chk("commit_chg_err", 64'(bus.chg_err), 64'd1);
      chk("commit_chg_avail", 64'(bus.buf_avail), 64'd1);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         step(logic'($urandom_range(0, 9) < 8), DB'($urandom_range(0, 3)),
              logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 2) == 0),
              int'($urandom_range(0, 300)) - 150, 0, '0);
      end

      idle();
      idle();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/proj_fm_ring.md
# proj_fm_ring

Parametrised N-buffer ring fragment memory, successor to the two-buffer fragment memory in the MinHash front end. Serial `DATA_BITS`-wide symbols stream into a ring of `BUFFER_COUNT` buffers under a valid/ready handshake, and committed buffers are promoted to *active* by `chg_idx`. Any `FRAG_LEN`-bit window of the active buffer is read with a signed bit index and one cycle of latency. Negative indices read from the tail of the previous (history) buffer, and out-of-range bits are zero-filled and flagged.

## Interface
Parameters:
- `BUFFER_COUNT`, 4: buffers in the ring; minimum 3 when `HIST_EN=1`, otherwise 2.
- `DATA_BITS`, 2: width of one written symbol.
- `DEPTH`, 64: symbols per buffer. `BUF_BITS = DEPTH*DATA_BITS`.
- `FRAG_LEN`, 32: read window width in bits.
- `SIGNED_INDICE_LEN`, 9: width of the two's-complement `frag_idx`; must represent ±`BUF_BITS`.
- `HIST_EN`, 1: keep the previous active buffer readable through negative indices.

Ports:
- `clk`, in, 1: clock. Everything is posedge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: write symbol valid.
- `in_wdata`, in, `DATA_BITS`: write symbol.
- `in_ready`, out, 1: a write buffer slot is free.
- `chg_idx`, in, 1: single-cycle request to advance the active buffer.
- `chg_err`, out, 1: one-cycle pulse when `chg_idx` is ignored.
- `rd_en`, in, 1: read request.
- `frag_idx`, in, `SIGNED_INDICE_LEN`: signed start bit of the window.
- `out_valid`, out, 1: `out_rdata` valid.
- `out_rdata`, out, `FRAG_LEN`: fragment.
- `out_oob`, out, 1: at least one bit of `out_rdata` was zero-filled.
- `buf_avail`, out, `$clog2(BUFFER_COUNT+1)`: committed buffers not yet activated.

## Operation
- State:
  - `wr_ptr`: write buffer index.
  - `wr_cnt`, 0..DEPTH-1.
  - `filled`: the committed FIFO count, output as `buf_avail`.
  - `act_ptr`, `act_vld`: active buffer.
  - `hist_ptr`, `hist_vld`: history buffer.
- Occupancy is `filled + act_vld + hist_vld`. `in_ready = (occupancy < BUFFER_COUNT)`.
- Write:
  - On `in_valid && in_ready`, symbol k goes to bits `[k*DATA_BITS +: DATA_BITS]` of buffer `wr_ptr`, and `wr_cnt` increments.
  - On symbol DEPTH-1 the buffer commits: `filled++`, `wr_ptr = (wr_ptr+1) mod BUFFER_COUNT`, `wr_cnt = 0`.
- `chg_idx` with `filled > 0`:
  - If `HIST_EN` and `act_vld`, history becomes the old active; otherwise the old active is freed. Any previous history is freed.
  - The active buffer becomes the oldest committed buffer, `act_vld = 1`, `filled--`.
- `chg_idx` with `filled == 0`: ignored, with `chg_err` high for the next cycle. Other state is unchanged.
- Commit and `chg_idx` in the same cycle:
  - The commit is not visible to that `chg_idx`.
  - With `filled == 0` this is a `chg_err`.
  - With `filled > 0`, `filled` is net unchanged.
- Read (`rd_en`): bit j of `out_rdata` comes from position `p = frag_idx + j`.
  - `0 <= p < BUF_BITS`: active bit p.
  - `p < 0`, `-BUF_BITS <= p`: history bit `BUF_BITS+p` if `HIST_EN && hist_vld`, else 0 with `out_oob=1`.
  - `p >= BUF_BITS` or `p < -BUF_BITS`: 0, `out_oob=1`.
  - `act_vld == 0`: `out_rdata = 0`, `out_oob = 1`, and `out_valid` is still asserted.
- Position arithmetic is signed with width `SIGNED_INDICE_LEN+1`, so `frag_idx + j` cannot wrap.

## Timing
- Reset (asynchronous, any time): all pointers, counters and valid flags clear, and partial or committed data is discarded. Outputs after reset:
  - `in_ready = 1`
  - `out_valid = 0`, `out_rdata = 0`, `out_oob = 0`
  - `chg_err = 0`
  - `buf_avail = 0`
- Read latency is 1: `rd_en` at edge n gives `out_valid`, `out_rdata` and `out_oob` registered at edge n+1. `out_valid` deasserts the cycle after `rd_en` drops. Back-to-back reads give one result per cycle.
- A read and `chg_idx` in the same cycle read the pre-change active and history buffers.
- A read and a write in the same cycle: the write never targets the active or history buffers, so there is no hazard.
- `in_ready` is combinational from registered state, so it drops in the cycle after the commit that fills the ring.
- `buf_avail` updates one cycle after the commit or `chg_idx` edge.

## Test plan
- **Reset:** `rst_n` low mid-write (after 30 symbols) → next cycle `in_ready=1`, `buf_avail=0`, `out_valid=0`. A read then gives `out_rdata=0`, `out_oob=1`.
- **Basic read:** write 64 symbols k%4, then `chg_idx`, then read `frag_idx=0` → one cycle later `out_rdata=32'hE4E4E4E4`, `out_oob=0`. `frag_idx=96` → same value, `out_oob=0`.
- **Top-edge window:** `frag_idx=100` → bits [27:0] = active[127:100], bits [31:28] = 0, `out_oob=1`.
- **History read:** buffer A all 2'b11, buffer B all 2'b00, `chg_idx` twice, read `frag_idx=-2` → `out_rdata=32'h00000003`, `out_oob=0`. With `HIST_EN=0` → `32'h0`, `out_oob=1`.
- **Backpressure (`BUFFER_COUNT=4`):** commit 4 buffers → `in_ready=0`, `buf_avail=4`. Then:
  - `chg_idx` ×2 → `in_ready` stays 0.
  - Third `chg_idx` → `in_ready=1`, `buf_avail=1`.
- **Empty change:** `chg_idx` with `buf_avail=0` → `chg_err` one-cycle pulse, active data unchanged. Commit and `chg_idx` in the same cycle with `buf_avail=0` → `chg_err=1`, `buf_avail=1` afterwards.
